// File: rtl/key_led_ctrl.sv
// Front-panel key debouncer and 4-mode LED controller (OFF, ON, SLOW blink, FAST blink).
// Raw key is synchronised, debounced into a single-cycle press event that steps the mode FSM.
module key_led_ctrl #(
  parameter int unsigned CNT_DEBOUNCE = 999_999,
  parameter int unsigned CNT_SLOW     = 24_999_999,
  parameter int unsigned CNT_FAST     = 4_999_999
) (
  input  logic       sys_clk,
  input  logic       sys_rst_n,
  input  logic       key_in,
  output logic       led_out,
  output logic [1:0] mode,
  output logic       key_flag
);

  localparam int unsigned DW = $clog2(CNT_DEBOUNCE + 1);
  localparam int unsigned BW = $clog2(CNT_SLOW + 1);

  localparam logic [DW-1:0] DEB_MAX   = DW'(CNT_DEBOUNCE);
  localparam logic [DW-1:0] DEB_LAST  = DW'(CNT_DEBOUNCE - 1);
  localparam logic [BW-1:0] SLOW_LAST = BW'(CNT_SLOW - 1);
  localparam logic [BW-1:0] FAST_LAST = BW'(CNT_FAST - 1);

  typedef enum logic [1:0] {
    ModeOff  = 2'd0,
    ModeOn   = 2'd1,
    ModeSlow = 2'd2,
    ModeFast = 2'd3
  } mode_e;

  logic          key_s1, key_s2;
  logic [DW-1:0] deb_cnt_q, deb_cnt_d;
  logic          key_flag_q, key_flag_d;
  mode_e         mode_q, mode_d;
  logic [BW-1:0] blink_cnt_q, blink_cnt_d;
  logic [BW-1:0] blink_last;
  logic          blink_q, blink_d;
  logic          led_q, led_d;

  // Synchronisers reset to the idle (released) level so reset never looks like a press.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      key_s1 <= 1'b1;
      key_s2 <= 1'b1;
    end else begin
      key_s1 <= key_in;
      key_s2 <= key_s1;
    end
  end

  // Counter saturates at the limit, so a held key yields exactly one event.
  always_comb begin
    deb_cnt_d  = deb_cnt_q;
    key_flag_d = 1'b0;
    if (key_s2) begin
      deb_cnt_d = '0;
    end else if (deb_cnt_q != DEB_MAX) begin
      deb_cnt_d  = deb_cnt_q + DW'(1);
      key_flag_d = (deb_cnt_q == DEB_LAST);
    end
  end

  always_comb begin
    mode_d = mode_q;
    if (key_flag_q) begin
      unique case (mode_q)
        ModeOff:  mode_d = ModeOn;
        ModeOn:   mode_d = ModeSlow;
        ModeSlow: mode_d = ModeFast;
        ModeFast: mode_d = ModeOff;
      endcase
    end
  end

  // Any mode change restarts the blink phase lit, so a blink mode always starts with LED on.
  always_comb begin
    blink_cnt_d = blink_cnt_q;
    blink_d     = blink_q;
    blink_last  = (mode_q == ModeSlow) ? SLOW_LAST : FAST_LAST;
    if (key_flag_q) begin
      blink_cnt_d = '0;
      blink_d     = 1'b1;
    end else if (mode_q == ModeSlow || mode_q == ModeFast) begin
      if (blink_cnt_q == blink_last) begin
        blink_cnt_d = '0;
        blink_d     = ~blink_q;
      end else begin
        blink_cnt_d = blink_cnt_q + BW'(1);
      end
    end else begin
      blink_cnt_d = '0;
    end
  end

  always_comb begin
    led_d = 1'b0;
    unique case (mode_q)
      ModeOff:  led_d = 1'b0;
      ModeOn:   led_d = 1'b1;
      ModeSlow: led_d = blink_q;
      ModeFast: led_d = blink_q;
    endcase
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      deb_cnt_q   <= '0;
      key_flag_q  <= 1'b0;
      mode_q      <= ModeOff;
      blink_cnt_q <= '0;
      blink_q     <= 1'b0;
      led_q       <= 1'b0;
    end else begin
      deb_cnt_q   <= deb_cnt_d;
      key_flag_q  <= key_flag_d;
      mode_q      <= mode_d;
      blink_cnt_q <= blink_cnt_d;
      blink_q     <= blink_d;
      led_q       <= led_d;
    end
  end

  assign led_out  = led_q;
  assign mode     = mode_q;
  assign key_flag = key_flag_q;

endmodule

// File: tb/tb_key_led_ctrl.sv
// Bench for key_led_ctrl: segment table, multi-cycle blink/hold/reset sequences and random key
// traffic, all compared every cycle against a history-based reference model.
module tb_key_led_ctrl;

  localparam int D = 4;
  localparam int S = 8;
  localparam int F = 2;

  logic       sys_clk = 1'b0;
  logic       sys_rst_n;
  logic       key_in;
  logic       led_out;
  logic [1:0] mode;
  logic       key_flag;

  int vectors     = 0;
  int miscompares = 0;
  int flag_seen   = 0;

  // Reference model: key history, expected outputs, edges since last mode change.
  logic hist[$];
  logic flag_m;
  int   mode_m;
  int   n_m;
  logic led_m;

  typedef struct {
    logic       key;
    int         cycles;
    int         flags;
    logic [1:0] exp_mode;
    logic       exp_led;
  } seg_t;

  seg_t segs[15];

  always #10 sys_clk = ~sys_clk;

  key_led_ctrl #(
    .CNT_DEBOUNCE(D),
    .CNT_SLOW    (S),
    .CNT_FAST    (F)
  ) dut (
    .sys_clk  (sys_clk),
    .sys_rst_n(sys_rst_n),
    .key_in   (key_in),
    .led_out  (led_out),
    .mode     (mode),
    .key_flag (key_flag)
  );

  function automatic logic blink_of(input int md, input int n);
    int l;
    l = (md == 2) ? S : F;
    return ((n / l) % 2) == 0;
  endfunction

  task automatic model_reset();
    hist.delete();
    hist.push_back(1'b1);
    hist.push_back(1'b1);
    flag_m = 1'b0;
    mode_m = 0;
    n_m    = 0;
    led_m  = 1'b0;
  endtask

  // One clock edge; k is the raw key value present at that edge.
  task automatic model_step(input logic k);
    int   run;
    int   old_mode;
    logic old_flag;
    old_mode = mode_m;
    old_flag = flag_m;
    case (old_mode)
      0:       led_m = 1'b0;
      1:       led_m = 1'b1;
      default: led_m = blink_of(old_mode, n_m);
    endcase
    // Length of the low run seen two edges late (sync delay); a press fires when it hits D.
    run = 0;
    for (int i = hist.size() - 2; i >= 0 && run <= D; i--) begin
      if (hist[i]) break;
      run++;
    end
    flag_m = (run == D);
    hist.push_back(k);
    if (hist.size() > D + 4) void'(hist.pop_front());
    if (old_flag) begin
      mode_m = (old_mode + 1) % 4;
      n_m    = 0;
    end else begin
      n_m++;
    end
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick(input logic k);
    key_in = k;
    @(posedge sys_clk);
    model_step(k);
    #1;
    check("led_out", led_out, led_m);
    check("mode", mode, mode_m);
    check("key_flag", key_flag, flag_m);
    if (key_flag === 1'b1) flag_seen++;
  endtask

  task automatic press();
    repeat (10) tick(1'b0);
    repeat (4) tick(1'b1);
  endtask

  // Called just after a tick; reset pulse lies entirely between clock edges.
  task automatic mid_reset();
    #4 sys_rst_n = 1'b0;
    #1;
    check("rst_led", led_out, 0);
    check("rst_mode", mode, 0);
    check("rst_flag", key_flag, 0);
    #1 sys_rst_n = 1'b1;
    model_reset();
  endtask

  task automatic measure_toggles(input int cycles, input int period, input string name);
    logic prev;
    int   last;
    int   changes;
    prev    = led_out;
    last    = -1;
    changes = 0;
    for (int c = 0; c < cycles; c++) begin
      tick(1'b1);
      if (led_out !== prev) begin
        if (last >= 0) check({name, "_period"}, c - last, period);
        last = c;
        changes++;
        prev = led_out;
      end
    end
    check({name, "_toggles"}, changes >= cycles / period - 1, 1);
  endtask

  initial begin
    segs[0] = '{1'b1, 20, 0, 2'd0, 1'b0};
    for (int i = 1; i <= 10; i++) segs[i] = '{logic'(i % 2 == 0), 3, 0, 2'd0, 1'b0};
    segs[11] = '{1'b0, 10, 1, 2'd1, 1'b1};
    segs[12] = '{1'b1, 5, 0, 2'd1, 1'b1};
    segs[13] = '{1'b0, 10, 1, 2'd2, 1'b1};
    segs[14] = '{1'b1, 4, 0, 2'd2, 1'b1};

    sys_rst_n = 1'b0;
    key_in    = 1'b1;
    model_reset();
    repeat (3) @(posedge sys_clk);
    #1;
    check("init_led", led_out, 0);
    check("init_mode", mode, 0);
    check("init_flag", key_flag, 0);
    @(negedge sys_clk);
    sys_rst_n = 1'b1;

    for (int i = 0; i < 15; i++) begin
      flag_seen = 0;
      repeat (segs[i].cycles) tick(segs[i].key);
      check($sformatf("seg%0d_flags", i), flag_seen, segs[i].flags);
      check($sformatf("seg%0d_mode", i), mode, segs[i].exp_mode);
      check($sformatf("seg%0d_led", i), led_out, segs[i].exp_led);
    end

    measure_toggles(40, S, "slow");
    press();
    check("fast_mode", mode, 3);
    measure_toggles(20, F, "fast");
    press();
    check("wrap_mode", mode, 0);
    check("wrap_led", led_out, 0);

    flag_seen = 0;
    repeat (50) tick(1'b0);
    repeat (4) tick(1'b1);
    check("hold_flags", flag_seen, 1);
    check("hold_mode", mode, 1);
    check("hold_led", led_out, 1);

    press();
    repeat (3) tick(1'b1);
    check("pre_rst_mode", mode, 2);
    mid_reset();
    repeat (5) tick(1'b1);
    press();
    check("post_rst_mode", mode, 1);
    check("post_rst_led", led_out, 1);

    for (int r = 0; r < 80; r++) begin
      int len;
      len = ($urandom_range(0, 3) == 0) ? int'($urandom_range(10, 30)) : int'($urandom_range(1, 8));
      repeat (len) tick(logic'(r % 2));
      if ($urandom_range(0, 9) == 0) mid_reset();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
